// File: rtl/jtag_scan_master_if.sv
// jtag_scan_master_if: command/response bundle between debug host logic and the JTAG scan master
interface jtag_scan_master_if #(
    parameter int MAX_LEN = 32,
    parameter int LW = $clog2(MAX_LEN + 1)
);
    logic start;
    logic ir_scan;
    logic reset_req;
    logic [LW-1:0] len;
    logic [MAX_LEN-1:0] tdi_data;
    logic busy;
    logic done;
    logic err;
    logic [MAX_LEN-1:0] tdo_data;
    modport master (
        output start, ir_scan, reset_req, len, tdi_data,
        input busy, done, err, tdo_data
    );
    modport slave (
        input start, ir_scan, reset_req, len, tdi_data,
        output busy, done, err, tdo_data
    );
endinterface

// File: rtl/jtag_scan_master.sv
// jtag_scan_master: turns IR/DR scan and TAP reset commands into TCK/TMS/TDI sequences and captures TDO
module jtag_scan_master #(
    parameter int MAX_LEN = 32,
    parameter int DIV = 2,
    parameter int LW = $clog2(MAX_LEN + 1)
) (
    input logic CLK,
    input logic RST,
    jtag_scan_master_if.slave bus,
    input logic TDO,
    output logic TCK,
    output logic TMS,
    output logic TDI
);
    localparam int PW = $clog2(2 * DIV);
    localparam logic [PW-1:0] P_LAST = PW'(2 * DIV - 1);
    localparam logic [PW-1:0] P_RISE = PW'(DIV - 1);
    localparam logic [PW-1:0] P_HIGH = PW'(DIV);
    localparam logic [2:0] TRESET = 3'd0;
    localparam logic [2:0] IDLE = 3'd1;
    localparam logic [2:0] HEAD = 3'd2;
    localparam logic [2:0] SHIFT = 3'd3;
    localparam logic [2:0] TAIL = 3'd4;

    logic [2:0] state_q, state_d;
    logic [PW-1:0] p_q, p_d;
    logic [LW-1:0] k_q, k_d;
    logic ir_q, ir_d;
    logic [LW-1:0] len_q, len_d;
    logic [MAX_LEN-1:0] data_q, data_d;
    logic [MAX_LEN-1:0] cap_q, cap_d;
    logic [MAX_LEN-1:0] tdo_q, tdo_d;
    logic busy_q, busy_d;
    logic done_q, done_d;
    logic err_q, err_d;
    logic tck_q, tck_d;
    logic tms_q, tms_d;
    logic tdi_q, tdi_d;
    logic bit_end;

    // Sequencer: phase/bit counters, command latch, TDO capture and completion
    always_comb begin
        state_d = state_q;
        p_d = p_q;
        k_d = k_q;
        ir_d = ir_q;
        len_d = len_q;
        data_d = data_q;
        cap_d = cap_q;
        tdo_d = tdo_q;
        done_d = 1'b0;
        err_d = 1'b0;
        bit_end = p_q == P_LAST;
        if (state_q == IDLE) begin
            if (bus.reset_req) begin
                state_d = TRESET;
                p_d = '0;
                k_d = '0;
            end else if (bus.start) begin
                if (bus.len == '0 || bus.len > LW'(MAX_LEN)) begin
                    done_d = 1'b1;
                    err_d = 1'b1;
                end else begin
                    state_d = HEAD;
                    p_d = '0;
                    k_d = '0;
                    ir_d = bus.ir_scan;
                    len_d = bus.len;
                    data_d = bus.tdi_data;
                    cap_d = '0;
                end
            end
        end else begin
            p_d = bit_end ? '0 : p_q + 1'b1;
            k_d = bit_end ? k_q + 1'b1 : k_q;
            // TDO is taken on the edge where TCK rises, as the target presents it then
            if (state_q == SHIFT && p_q == P_RISE)
                cap_d = cap_q | (MAX_LEN'(TDO) << k_q);
            if (bit_end) begin
                if (state_q == TRESET && k_q == LW'(5)) begin
                    state_d = IDLE;
                    done_d = 1'b1;
                end else if (state_q == HEAD && k_q == (ir_q ? LW'(3) : LW'(2))) begin
                    state_d = SHIFT;
                    k_d = '0;
                end else if (state_q == SHIFT && k_q == len_q - 1'b1) begin
                    state_d = TAIL;
                    k_d = '0;
                end else if (state_q == TAIL && k_q == LW'(1)) begin
                    state_d = IDLE;
                    done_d = 1'b1;
                    tdo_d = cap_q;
                end
            end
        end
    end

    // Pin values derived from the next bit position so they are registered glitch-free
    always_comb begin
        busy_d = state_d != IDLE;
        tck_d = busy_d && p_d >= P_HIGH;
        tms_d = state_d == TRESET ? k_d != LW'(5) :
                state_d == HEAD ? (k_d == '0 || (ir_d && k_d == LW'(1))) :
                state_d == SHIFT ? k_d == len_d - 1'b1 :
                state_d == TAIL ? k_d == '0 : 1'b0;
        tdi_d = state_d == SHIFT && |(data_d & (MAX_LEN'(1) << k_d));
    end

    // State registers; reset parks the counters one tick before TRESET bit 0
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= TRESET;
            p_q <= P_LAST;
            k_q <= '1;
            ir_q <= 1'b0;
            len_q <= '0;
            data_q <= '0;
            cap_q <= '0;
            tdo_q <= '0;
            busy_q <= 1'b1;
            done_q <= 1'b0;
            err_q <= 1'b0;
            tck_q <= 1'b0;
            tms_q <= 1'b1;
            tdi_q <= 1'b0;
        end else begin
            state_q <= state_d;
            p_q <= p_d;
            k_q <= k_d;
            ir_q <= ir_d;
            len_q <= len_d;
            data_q <= data_d;
            cap_q <= cap_d;
            tdo_q <= tdo_d;
            busy_q <= busy_d;
            done_q <= done_d;
            err_q <= err_d;
            tck_q <= tck_d;
            tms_q <= tms_d;
            tdi_q <= tdi_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.err = err_q;
    assign bus.tdo_data = tdo_q;
    assign TCK = tck_q;
    assign TMS = tms_q;
    assign TDI = tdi_q;
endmodule

// File: tb/tb_jtag_scan_master.sv
// tb_jtag_scan_master: scoreboard bench for jtag_scan_master with a loopback/tied TDO target
module tb_jtag_scan_master;
    typedef struct packed {
        logic err;
        logic [31:0] tdo;
        logic [7:0] n;
        logic [63:0] tms;
        logic [63:0] tdi;
        int t;
        int lat;
    } exp_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic TCK, TMS, TDI, TDO;
    logic lb = 1'b0;
    logic use_lb = 1'b1;
    logic tie = 1'b0;
    int cyc = 0;
    int compares = 0;
    int mism = 0;
    exp_t sb[$];

    jtag_scan_master_if #(.MAX_LEN(32)) bus();

    jtag_scan_master #(.MAX_LEN(32), .DIV(2)) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus),
        .TDO(TDO),
        .TCK(TCK),
        .TMS(TMS),
        .TDI(TDI)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Target: TDO replays the TDI it sampled on the previous TCK rise
    always @(posedge TCK) lb <= TDI;
    assign TDO = use_lb ? lb : tie;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        compares++;
        if (act !== exp) begin
            mism++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic exp_t mk(input logic err, input logic [31:0] tdo, input logic [7:0] n,
                                input logic [63:0] tms, input logic [63:0] tdi, input int lat);
        exp_t e;
        e.err = err;
        e.tdo = tdo;
        e.n = n;
        e.tms = tms;
        e.tdi = tdi;
        e.t = 0;
        e.lat = lat;
        return e;
    endfunction

    // Monitor: records TMS/TDI at each TCK rise and checks every done against the scoreboard
    initial begin
        int n;
        logic prev;
        logic [63:0] tms_s, tdi_s;
        exp_t e;
        n = 0;
        prev = 1'b0;
        tms_s = '0;
        tdi_s = '0;
        forever begin
            @(negedge CLK);
            if (RST) begin
                n = 0;
                prev = 1'b0;
                tms_s = '0;
                tdi_s = '0;
            end else begin
                if (TCK && !prev && n < 64) begin
                    tms_s[n] = TMS;
                    tdi_s[n] = TDI;
                    n++;
                end
                prev = TCK;
                if (!bus.busy) chk("tck_low_when_idle", 64'(TCK), 64'd0);
                if (bus.done) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_done", 64'd1, 64'd0);
                    end else begin
                        e = sb.pop_front();
                        chk("err", 64'(bus.err), 64'(e.err));
                        chk("tdo_data", 64'(bus.tdo_data), 64'(e.tdo));
                        chk("tck_count", 64'(n), 64'(e.n));
                        chk("tms_seq", tms_s, e.tms);
                        chk("tdi_seq", tdi_s, e.tdi);
                        chk("latency", 64'(cyc - e.t), 64'(e.lat));
                    end
                    n = 0;
                    tms_s = '0;
                    tdi_s = '0;
                end
            end
        end
    end

    task automatic issue(input logic ir, input logic [5:0] l, input logic [31:0] d,
                         input logic rr, input logic push, input exp_t e);
        exp_t x;
        @(negedge CLK);
        bus.start = 1'b1;
        bus.ir_scan = ir;
        bus.len = l;
        bus.tdi_data = d;
        bus.reset_req = rr;
        x = e;
        x.t = cyc + 1;
        if (push) sb.push_back(x);
        @(negedge CLK);
        bus.start = 1'b0;
        bus.reset_req = 1'b0;
    endtask

    task automatic wait_done(input int lim);
        logic ok;
        ok = bus.done;
        for (int i = 0; i < lim && !ok; i++) begin
            @(negedge CLK);
            ok = bus.done;
        end
        if (!ok) chk("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"}, 64'(bus.busy), 64'd1);
        chk({tag, "_done"}, 64'(bus.done), 64'd0);
        chk({tag, "_err"}, 64'(bus.err), 64'd0);
        chk({tag, "_tdo_data"}, 64'(bus.tdo_data), 64'd0);
        chk({tag, "_tck"}, 64'(TCK), 64'd0);
        chk({tag, "_tms"}, 64'(TMS), 64'd1);
        chk({tag, "_tdi"}, 64'(TDI), 64'd0);
    endtask

    initial begin
        exp_t e;
        bus.start = 1'b0;
        bus.ir_scan = 1'b0;
        bus.len = '0;
        bus.tdi_data = '0;
        bus.reset_req = 1'b0;
        repeat (3) @(negedge CLK);
        chk_reset_vals("rst");
        // Reset release: TRESET of 6 bits, done 24 cycles after the first un-reset edge
        RST = 1'b0;
        e = mk(1'b0, 32'h0, 8'd6, 64'h1F, 64'h0, 24);
        e.t = cyc + 1;
        sb.push_back(e);
        wait_done(100);
        chk("post_treset_busy", 64'(bus.busy), 64'd0);
        chk("post_treset_tms", 64'(TMS), 64'd0);
        // DR scan len 8 of 0xA5 with loopback target
        use_lb = 1'b1;
        issue(1'b0, 6'd8, 32'hA5, 1'b0, 1'b1, mk(1'b0, 32'h4A, 8'd13, 64'hC01, 64'h528, 52));
        wait_done(200);
        // IR scan len 4 of 0x6 with TDO tied high
        use_lb = 1'b0;
        tie = 1'b1;
        issue(1'b1, 6'd4, 32'h6, 1'b0, 1'b1, mk(1'b0, 32'hF, 8'd10, 64'h183, 64'h60, 40));
        wait_done(200);
        // Illegal lengths: immediate done+err, tdo_data kept
        issue(1'b0, 6'd0, 32'hFFFF, 1'b0, 1'b1, mk(1'b1, 32'hF, 8'd0, 64'h0, 64'h0, 0));
        wait_done(20);
        issue(1'b0, 6'd33, 32'hFFFF, 1'b0, 1'b1, mk(1'b1, 32'hF, 8'd0, 64'h0, 64'h0, 0));
        wait_done(20);
        // start and reset_req together: reset wins
        issue(1'b0, 6'd8, 32'hFF, 1'b1, 1'b1, mk(1'b0, 32'hF, 8'd6, 64'h1F, 64'h0, 24));
        wait_done(100);
        // DR scan len 3 of 0x5 with a stray start mid-scan
        use_lb = 1'b1;
        tie = 1'b0;
        issue(1'b0, 6'd3, 32'h5, 1'b0, 1'b1, mk(1'b0, 32'h2, 8'd8, 64'h61, 64'h28, 32));
        repeat (8) @(negedge CLK);
        bus.start = 1'b1;
        bus.len = 6'd2;
        bus.tdi_data = 32'h3;
        @(negedge CLK);
        bus.start = 1'b0;
        wait_done(100);
        repeat (40) @(negedge CLK);
        // Reset during bit 5 of a DR scan: abort, then full TRESET with cleared capture
        issue(1'b0, 6'd8, 32'hFF, 1'b0, 1'b0, mk(1'b0, 32'h0, 8'd0, 64'h0, 64'h0, 0));
        repeat (20) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        chk_reset_vals("midrst");
        RST = 1'b0;
        e = mk(1'b0, 32'h0, 8'd6, 64'h1F, 64'h0, 24);
        e.t = cyc + 1;
        sb.push_back(e);
        wait_done(100);
        repeat (10) @(negedge CLK);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, mism);
        $finish;
    end
endmodule
